// File: rtl/pipe_mem_arbiter.sv
// Shares the M-stage data RAM between the CPU load/store port and a debug/DMA port.
// The CPU has priority. Define PIPE_MEM_ARBITER_STARVE_GUARD_EN to bound how long the debug port can wait.
module pipe_mem_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_DBG = 2'd1,
    S_ACK = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] hold_addr_reg;
  logic          hold_we_reg;
  logic [DW-1:0] hold_wdata_reg;
  logic [DW-1:0] d_rdata_reg;
  logic          guard_fire;
  logic          grant;

  // The debug port gets the RAM only in an idle CPU cycle, or when the guard forces it in.
  assign grant = (state_reg == S_CPU) && d_req && (!c_req || guard_fire);

`ifdef PIPE_MEM_ARBITER_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_reg <= 8'd0;
    end else if (!d_req || grant) begin
      starve_cnt_reg <= 8'd0;
    end else if (state_reg == S_CPU && c_req && starve_cnt_reg != 8'hFF) begin
      starve_cnt_reg <= starve_cnt_reg + 8'd1;
    end
  end

  assign guard_fire = (starve_cnt_reg == LIMIT);
`else
  assign guard_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_CPU;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_addr     = c_addr;
    m_wdata    = c_wdata;
    m_we       = c_req & c_we;
    c_stall    = 1'b0;
    case (state_reg)
      S_CPU: begin
        if (grant) begin
          state_next = S_DBG;
        end
      end
      S_DBG: begin
        m_addr     = hold_addr_reg;
        m_wdata    = hold_wdata_reg;
        m_we       = hold_we_reg;
        c_stall    = c_req;
        state_next = S_ACK;
      end
      S_ACK: begin
        state_next = S_CPU;
      end
      default: begin
        state_next = S_CPU;
      end
    endcase
  end

  // Debug fields are frozen at grant so a requester dropping d_req mid-access cannot corrupt it.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_addr_reg  <= '0;
      hold_we_reg    <= 1'b0;
      hold_wdata_reg <= '0;
    end else if (grant) begin
      hold_addr_reg  <= d_addr;
      hold_we_reg    <= d_we;
      hold_wdata_reg <= d_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_rdata_reg <= '0;
    end else if (state_reg == S_DBG && !hold_we_reg) begin
      d_rdata_reg <= m_rdata;
    end
  end

  assign d_ack   = (state_reg == S_ACK);
  assign d_rdata = d_rdata_reg;
  assign c_rdata = m_rdata;

endmodule
